scr_data_sel_reg: RTL and testbench

Parametrised, registered successor to the scratch-RAM data-select mux. It takes N request channels, each carrying a DATA_W-bit word. Channels marked narrow are zero-extended from NARROW_W. The block arbitrates among active requests and loads the winning word into a one-deep output register. The scratch-RAM write port drains that register through a valid/ready handshake. It sits between the datapath sources (register file, PC, flags) and the scratch RAM DATA_IN port.

---
 rtl/scr_data_sel_pkg.sv | 12 +
 rtl/scr_rr_arbiter.sv | 60 ++++++
 rtl/scr_data_sel_reg.sv | 67 ++++++
 tb/tb_scr_data_sel_reg.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr_data_sel_pkg.sv
// scr_data_sel_pkg: shared constants and helpers for the
// scratch-RAM data-select register.
package scr_data_sel_pkg;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_NARROW_W = 8;

  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scr_rr_arbiter.sv
// scr_rr_arbiter: one-hot grant plus index; round-robin pointer
// when SCR_DATA_SEL_RR_EN is defined, else lowest-index-first.
module scr_rr_arbiter
  import scr_data_sel_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                en,
  output logic [N-1:0]        gnt,
  output logic [src_w(N)-1:0] idx
);

  localparam int SW = src_w(N);

  logic [SW-1:0] win;

`ifdef SCR_DATA_SEL_RR_EN
  logic [SW-1:0] ptr;
  int            c;

  // Walk from the far end so the nearest requester to ptr wins.
  always_comb begin
    win = '0;
    c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) win = SW'(c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && |req) begin
      ptr <= (win == SW'(N - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) win = SW'(k);
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (en && |req) gnt[win] = 1'b1;
  end

  assign idx = win;

endmodule

// File: rtl/scr_data_sel_reg.sv
// scr_data_sel_reg: arbitrated, registered scratch-RAM data select.
// Define SCR_DATA_SEL_RR_EN for round-robin arbitration.
module scr_data_sel_reg
  import scr_data_sel_pkg::*;
#(
  parameter int           N           = 2,
  parameter int           DATA_W      = DEF_DATA_W,
  parameter int           NARROW_W    = DEF_NARROW_W,
  parameter logic [N-1:0] NARROW_MASK = 'b01
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N-1:0]          REQ,
  input  logic [N*DATA_W-1:0]   DIN,
  output logic [N-1:0]          GNT,
  output logic [DATA_W-1:0]     OUT,
  output logic [src_w(N)-1:0]   OUT_SRC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int SW = src_w(N);
  localparam logic [DATA_W-1:0] LOW_MASK =
    DATA_W'((64'd1 << NARROW_W) - 64'd1);

  logic              accept;
  logic [N-1:0]      grant;
  logic [SW-1:0]     win;
  logic [DATA_W-1:0] sel;
  logic [DATA_W-1:0] word;

  // Gated by RST so no source sees a grant during reset.
  assign accept = !RST && (!OUT_VALID || OUT_READY) && |REQ;

  scr_rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk (CLK),
    .rst (RST),
    .req (REQ),
    .en  (accept),
    .gnt (grant),
    .idx (win)
  );

  assign GNT = grant;

  always_comb begin
    sel  = DIN[int'(win)*DATA_W +: DATA_W];
    word = NARROW_MASK[win] ? (sel & LOW_MASK) : sel;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT       <= '0;
      OUT_SRC   <= '0;
      OUT_VALID <= 1'b0;
    end else if (accept) begin
      OUT       <= word;
      OUT_SRC   <= win;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scr_data_sel_reg.sv
// tb_scr_data_sel_reg: directed N=2 scenarios plus an N=4
// instance checked against a behavioural arbitration model.
module tb_scr_data_sel_reg;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [1:0]  req2, gnt2;
  logic [19:0] din2;
  logic [9:0]  out2;
  logic [0:0]  src2;
  logic        v2, rdy2;

  logic [3:0]  req4, gnt4;
  logic [39:0] din4;
  logic [9:0]  out4;
  logic [1:0]  src4;
  logic        v4, rdy4;

  localparam logic [3:0] MASK4 = 4'b0101;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] m_out;
  int         m_src;
  bit         m_valid;
  int         m_ptr;

  scr_data_sel_reg #(
    .N (2), .DATA_W (10), .NARROW_W (8), .NARROW_MASK (2'b01)
  ) dut2 (
    .CLK (CLK), .RST (RST), .REQ (req2), .DIN (din2),
    .GNT (gnt2), .OUT (out2), .OUT_SRC (src2),
    .OUT_VALID (v2), .OUT_READY (rdy2)
  );

  scr_data_sel_reg #(
    .N (4), .DATA_W (10), .NARROW_W (8), .NARROW_MASK (MASK4)
  ) dut4 (
    .CLK (CLK), .RST (RST), .REQ (req4), .DIN (din4),
    .GNT (gnt4), .OUT (out4), .OUT_SRC (src4),
    .OUT_VALID (v4), .OUT_READY (rdy4)
  );

  function automatic int pick4(input logic [3:0] r, input int p);
`ifdef SCR_DATA_SEL_RR_EN
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
`else
    for (int k = 0; k < 4; k++)
      if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic reset_all();
    @(negedge CLK);
    RST  = 1'b1;
    req2 = '0; din2 = '0; rdy2 = 1'b1;
    req4 = '0; din4 = '0; rdy4 = 1'b1;
    m_out = '0; m_src = 0; m_valid = 0; m_ptr = 0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Inputs are applied at the negedge before this is called.
  task automatic cycle4(input string tag, output int w);
    logic [3:0] eg;
    logic [9:0] word;
    bit acc;
    #1;
    acc = (!m_valid || rdy4) && (req4 != 4'b0);
    w   = acc ? pick4(req4, m_ptr) : -1;
    eg  = (w >= 0) ? 4'(1 << w) : 4'b0;
    n_chk++;
    if (gnt4 !== eg) begin
      n_fail++;
      $display("FAIL %s gnt4: got %b want %b", tag, gnt4, eg);
    end
    if (w >= 0) begin
      word = din4[w*10 +: 10];
      if (MASK4[w]) word = word % 256;
      m_out = word; m_src = w; m_valid = 1; m_ptr = (w + 1) % 4;
    end else if (rdy4) begin
      m_valid = 0;
    end
    @(posedge CLK); #1;
    n_chk++;
    if (out4 !== m_out || src4 !== 2'(m_src) || v4 !== m_valid) begin
      n_fail++;
      $display("FAIL %s out4: got %h/%0d/%b want %h/%0d/%b",
               tag, out4, src4, v4, m_out, m_src, m_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; req2 = 2'b11; din2 = '0; rdy2 = 1'b1;
    req4 = 4'b1111; din4 = '0; rdy4 = 1'b1;
    #1;
    n_chk++;
    if (out2 !== 10'h0 || v2 !== 1'b0 || src2 !== 1'b0 || gnt2 !== 2'b00) begin
      n_fail++;
      $display("FAIL reset2: got %h/%b/%b/%b want 0/0/0/00", out2, src2, v2, gnt2);
    end
    n_chk++;
    if (gnt4 !== 4'b0 || v4 !== 1'b0 || out4 !== 10'h0) begin
      n_fail++;
      $display("FAIL reset4: got %b/%b/%h want 0000/0/000", gnt4, v4, out4);
    end
    reset_all();
  endtask

  task automatic test_zext();
    @(negedge CLK);
    req2 = 2'b01; din2 = {10'h000, 10'h3A5}; rdy2 = 1'b1;
    #1; n_chk++;
    if (gnt2 !== 2'b01) begin
      n_fail++; $display("FAIL zext gnt0: got %b want 01", gnt2);
    end
    @(posedge CLK); #1; n_chk++;
    if (out2 !== 10'h0A5 || src2 !== 1'b0 || v2 !== 1'b1) begin
      n_fail++;
      $display("FAIL zext out0: got %h/%b/%b want 0a5/0/1", out2, src2, v2);
    end
    @(negedge CLK);
    req2 = 2'b10; din2 = {10'h3A5, 10'h000};
    #1; n_chk++;
    if (gnt2 !== 2'b10) begin
      n_fail++; $display("FAIL zext gnt1: got %b want 10", gnt2);
    end
    @(posedge CLK); #1; n_chk++;
    if (out2 !== 10'h3A5 || src2 !== 1'b1) begin
      n_fail++; $display("FAIL zext out1: got %h/%b want 3a5/1", out2, src2);
    end
  endtask

  task automatic test_stall();
    @(negedge CLK);
    req2 = 2'b10; din2 = {10'h155, 10'h0AB}; rdy2 = 1'b1;
    @(posedge CLK); #1; n_chk++;
    if (out2 !== 10'h155 || v2 !== 1'b1) begin
      n_fail++; $display("FAIL stall load: got %h/%b want 155/1", out2, v2);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      req2 = 2'b11; rdy2 = 1'b0;
      #1; n_chk++;
      if (gnt2 !== 2'b00) begin
        n_fail++; $display("FAIL stall gnt c%0d: got %b want 00", i, gnt2);
      end
      @(posedge CLK); #1; n_chk++;
      if (out2 !== 10'h155 || src2 !== 1'b1 || v2 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall hold c%0d: got %h/%b/%b want 155/1/1", i, out2, src2, v2);
      end
    end
    @(negedge CLK);
    rdy2 = 1'b1;
    #1; n_chk++;
    if (gnt2 !== 2'b01) begin
      n_fail++; $display("FAIL stall release gnt: got %b want 01", gnt2);
    end
    @(posedge CLK); #1; n_chk++;
    if (out2 !== 10'h0AB || src2 !== 1'b0 || v2 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall release out: got %h/%b/%b want 0ab/0/1", out2, src2, v2);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      req2 = 2'b01; rdy2 = 1'b1; din2 = {10'h3FF, 10'(k)};
      #1; n_chk++;
      if (gnt2 !== 2'b01) begin
        n_fail++; $display("FAIL b2b gnt %0d: got %b want 01", k, gnt2);
      end
      @(posedge CLK); #1; n_chk++;
      if (out2 !== 10'(k) || v2 !== 1'b1) begin
        n_fail++; $display("FAIL b2b out %0d: got %h/%b want %h/1", k, out2, v2, 10'(k));
      end
    end
    @(negedge CLK);
    req2 = 2'b00;
    @(posedge CLK); #1; n_chk++;
    if (v2 !== 1'b0 || out2 !== 10'h004 || src2 !== 1'b0) begin
      n_fail++; $display("FAIL drain: got %h/%b/%b want 004/0/0", out2, src2, v2);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge CLK);
    req2 = 2'b01; din2 = {10'h000, 10'h077}; rdy2 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1; n_chk++;
    if (out2 !== 10'h0 || v2 !== 1'b0 || gnt2 !== 2'b00) begin
      n_fail++;
      $display("FAIL reset mid-stall: got %h/%b/%b want 000/0/00", out2, v2, gnt2);
    end
    reset_all();
  endtask

  task automatic test_arb4();
    int w;
    int exp_src[5];
`ifdef SCR_DATA_SEL_RR_EN
    exp_src = '{0, 1, 2, 3, 0};
`else
    exp_src = '{0, 0, 0, 0, 0};
`endif
    reset_all();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      req4 = 4'b1111; rdy4 = 1'b1;
      din4 = {10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)};
      cycle4("arb", w);
      n_chk++;
      if (src4 !== 2'(exp_src[i])) begin
        n_fail++; $display("FAIL arb src %0d: got %0d want %0d", i, src4, exp_src[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int w;
    int exp3;
`ifdef SCR_DATA_SEL_RR_EN
    exp3 = 3;
`else
    exp3 = 0;
`endif
    reset_all();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      req4 = 4'b1111; din4 = {4{10'($urandom)}};
      cycle4("wrap pre", w);
    end
    @(negedge CLK);
    req4 = 4'b1001;
    cycle4("wrap 1001", w);
    n_chk++;
    if (src4 !== 2'(exp3)) begin
      n_fail++; $display("FAIL wrap src: got %0d want %0d", src4, exp3);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      req4 = 4'b0000;
      cycle4("wrap idle", w);
    end
    n_chk++;
    if (v4 !== 1'b0) begin
      n_fail++; $display("FAIL wrap idle valid: got %b want 0", v4);
    end
    @(negedge CLK);
    req4 = 4'b1111;
    cycle4("wrap after", w);
    n_chk++;
    if (src4 !== 2'd0) begin
      n_fail++; $display("FAIL wrap ptr kept: got %0d want 0", src4);
    end
  endtask

  task automatic test_random();
    int w;
    reset_all();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      for (int c = 0; c < 4; c++) begin
        if (!req4[c] && $urandom_range(1, 0) == 1) begin
          req4[c] = 1'b1;
          din4[c*10 +: 10] = 10'($urandom);
        end
      end
      rdy4 = ($urandom_range(3, 0) != 0);
      cycle4("rand", w);
      if (w >= 0) req4[w] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_zext();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
    test_arb4();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
